// File: rtl/gps_ca_correlator.sv
// rtl/gps_ca_correlator.sv - single-channel GPS L1 C/A correlator: carrier wipeoff, despread, epoch integrate-and-dump
module gps_ca_correlator #(
    parameter int SPC   = 4,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [2:0]       real_in,
    input  logic [2:0]       imag_in,
    input  logic [31:0]      freq,
    input  logic [5:0]       ca_sel,
    input  logic [9:0]       code_phase,
    input  logic             start,
    output logic             busy,
    output logic             code_chip,
    output logic [ACC_W-1:0] corr_i,
    output logic [ACC_W-1:0] corr_q,
    output logic             corr_valid,
    output logic [15:0]      epoch_cnt
);

    localparam int               SPC_W     = (SPC > 1) ? $clog2(SPC) : 1;
    localparam logic [SPC_W-1:0] SPC_LAST  = SPC_W'(SPC - 1);
    localparam logic [9:0]       CHIP_LAST = 10'd1022;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLEW = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // One-hot mask for LFSR stage n (stages numbered 1..10, stage k held in bit k-1)
    function automatic logic [9:0] stage_mask(input logic [3:0] n);
        stage_mask = 10'd1 << (n - 4'd1);
    endfunction

    // G2 output tap pair {ta, tb} for PRN sel+1; unused selects fall back to PRN 1
    function automatic logic [7:0] prn_taps(input logic [5:0] sel);
        case (sel)
            6'd0:    prn_taps = {4'd2, 4'd6};
            6'd1:    prn_taps = {4'd3, 4'd7};
            6'd2:    prn_taps = {4'd4, 4'd8};
            6'd3:    prn_taps = {4'd5, 4'd9};
            6'd4:    prn_taps = {4'd1, 4'd9};
            6'd5:    prn_taps = {4'd2, 4'd10};
            6'd6:    prn_taps = {4'd1, 4'd8};
            6'd7:    prn_taps = {4'd2, 4'd9};
            6'd8:    prn_taps = {4'd3, 4'd10};
            6'd9:    prn_taps = {4'd2, 4'd3};
            6'd10:   prn_taps = {4'd3, 4'd4};
            6'd11:   prn_taps = {4'd5, 4'd6};
            6'd12:   prn_taps = {4'd6, 4'd7};
            6'd13:   prn_taps = {4'd7, 4'd8};
            6'd14:   prn_taps = {4'd8, 4'd9};
            6'd15:   prn_taps = {4'd9, 4'd10};
            6'd16:   prn_taps = {4'd1, 4'd4};
            6'd17:   prn_taps = {4'd2, 4'd5};
            6'd18:   prn_taps = {4'd3, 4'd6};
            6'd19:   prn_taps = {4'd4, 4'd7};
            6'd20:   prn_taps = {4'd5, 4'd8};
            6'd21:   prn_taps = {4'd6, 4'd9};
            6'd22:   prn_taps = {4'd1, 4'd3};
            6'd23:   prn_taps = {4'd4, 4'd6};
            6'd24:   prn_taps = {4'd5, 4'd7};
            6'd25:   prn_taps = {4'd6, 4'd8};
            6'd26:   prn_taps = {4'd7, 4'd9};
            6'd27:   prn_taps = {4'd8, 4'd10};
            6'd28:   prn_taps = {4'd1, 4'd6};
            6'd29:   prn_taps = {4'd2, 4'd7};
            6'd30:   prn_taps = {4'd3, 4'd8};
            6'd31:   prn_taps = {4'd4, 4'd9};
            6'd32:   prn_taps = {4'd5, 4'd10};
            6'd33:   prn_taps = {4'd4, 4'd10};
            6'd34:   prn_taps = {4'd1, 4'd7};
            6'd35:   prn_taps = {4'd2, 4'd8};
            default: prn_taps = {4'd2, 4'd6};
        endcase
    endfunction

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic [31:0]      freq_q, freq_d;
    logic [5:0]       ca_sel_q, ca_sel_d;
    logic [9:0]       slew_q, slew_d;
    logic [9:0]       g1_q, g1_d;
    logic [9:0]       g2_q, g2_d;
    logic [9:0]       code_idx_q, code_idx_d;
    logic [31:0]      phase_q, phase_d;
    logic [SPC_W-1:0] spc_cnt_q, spc_cnt_d;
    logic [9:0]       chip_cnt_q, chip_cnt_d;
    logic             w_valid_q, w_valid_d;
    logic             w_last_q, w_last_d;
    logic [3:0]       wi_q, wi_d;
    logic [3:0]       wq_q, wq_d;
    logic [ACC_W-1:0] acc_i_q, acc_i_d;
    logic [ACC_W-1:0] acc_q_q, acc_q_d;
    logic [ACC_W-1:0] corr_i_q, corr_i_d;
    logic [ACC_W-1:0] corr_q_q, corr_q_d;
    logic             corr_valid_q, corr_valid_d;
    logic [15:0]      epoch_q, epoch_d;

    logic [7:0]       tap_ab;
    logic [9:0]       mask_a, mask_b;
    logic [9:0]       g1_step, g2_step;
    logic             cs_neg, ss_neg;
    logic [3:0]       r_ext, i_ext, r_cs, r_ss, i_cs, i_ss;
    logic [3:0]       wipe_i, wipe_q, desp_i, desp_q;
    logic [ACC_W-1:0] sum_i, sum_q;
    logic             advance;

    // Local code: G1 stage 10 xor the selected G2 tap pair
    assign tap_ab    = prn_taps(ca_sel_q);
    assign mask_a    = stage_mask(tap_ab[7:4]);
    assign mask_b    = stage_mask(tap_ab[3:0]);
    assign code_chip = g1_q[9] ^ (^(g2_q & mask_a)) ^ (^(g2_q & mask_b));
    assign g1_step   = {g1_q[8:0], g1_q[2] ^ g1_q[9]};
    assign g2_step   = {g2_q[8:0], g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9]};

    // Quadrant signs from the top two phase bits: cos negative in 01/10, sin negative in 10/11
    assign cs_neg = phase_q[31] ^ phase_q[30];
    assign ss_neg = phase_q[31];
    assign r_ext  = {real_in[2], real_in};
    assign i_ext  = {imag_in[2], imag_in};
    assign r_cs   = cs_neg ? (4'd0 - r_ext) : r_ext;
    assign r_ss   = ss_neg ? (4'd0 - r_ext) : r_ext;
    assign i_cs   = cs_neg ? (4'd0 - i_ext) : i_ext;
    assign i_ss   = ss_neg ? (4'd0 - i_ext) : i_ext;
    assign wipe_i = r_cs + i_ss;
    assign wipe_q = i_cs - r_ss;
    assign desp_i = code_chip ? (4'd0 - wipe_i) : wipe_i;
    assign desp_q = code_chip ? (4'd0 - wipe_q) : wipe_q;

    // Accumulate stage adds the registered despread sample to the running sums
    assign sum_i = acc_i_q + {{(ACC_W-4){wi_q[3]}}, wi_q};
    assign sum_q = acc_q_q + {{(ACC_W-4){wq_q[3]}}, wq_q};

    // Next-state logic: start reload, code slew, sample consumption and dump
    always_comb begin
        state_d      = state_q;
        freq_d       = freq_q;
        ca_sel_d     = ca_sel_q;
        slew_d       = slew_q;
        g1_d         = g1_q;
        g2_d         = g2_q;
        code_idx_d   = code_idx_q;
        phase_d      = phase_q;
        spc_cnt_d    = spc_cnt_q;
        chip_cnt_d   = chip_cnt_q;
        w_valid_d    = 1'b0;
        w_last_d     = 1'b0;
        wi_d         = wi_q;
        wq_d         = wq_q;
        acc_i_d      = acc_i_q;
        acc_q_d      = acc_q_q;
        corr_i_d     = corr_i_q;
        corr_q_d     = corr_q_q;
        corr_valid_d = 1'b0;
        epoch_d      = epoch_q;
        advance      = 1'b0;

        if (start) begin
            // Reload drops any in-flight sample and suppresses a coincident dump
            state_d    = ST_SLEW;
            freq_d     = freq;
            ca_sel_d   = ca_sel;
            slew_d     = (code_phase == 10'd1023) ? 10'd0 : code_phase;
            g1_d       = '1;
            g2_d       = '1;
            code_idx_d = '0;
            phase_d    = '0;
            spc_cnt_d  = '0;
            chip_cnt_d = '0;
            acc_i_d    = '0;
            acc_q_d    = '0;
            epoch_d    = '0;
        end else begin
            if (w_valid_q) begin
                if (w_last_q) begin
                    corr_i_d     = sum_i;
                    corr_q_d     = sum_q;
                    corr_valid_d = 1'b1;
                    epoch_d      = epoch_q + 16'd1;
                    acc_i_d      = '0;
                    acc_q_d      = '0;
                end else begin
                    acc_i_d = sum_i;
                    acc_q_d = sum_q;
                end
            end

            case (state_q)
                ST_SLEW: begin
                    if (slew_q != 10'd0) begin
                        advance = 1'b1;
                        slew_d  = slew_q - 10'd1;
                    end
                    if (slew_q <= 10'd1) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_valid_d = 1'b1;
                    w_last_d  = (chip_cnt_q == CHIP_LAST) && (spc_cnt_q == SPC_LAST);
                    wi_d      = desp_i;
                    wq_d      = desp_q;
                    phase_d   = phase_q + freq_q;
                    if (spc_cnt_q == SPC_LAST) begin
                        spc_cnt_d  = '0;
                        advance    = 1'b1;
                        chip_cnt_d = (chip_cnt_q == CHIP_LAST) ? 10'd0 : chip_cnt_q + 10'd1;
                    end else begin
                        spc_cnt_d = spc_cnt_q + SPC_W'(1);
                    end
                end
                default: begin
                end
            endcase

            // The code period is 1023 chips; forcing all ones at the wrap keeps G1/G2 in lockstep with the index
            if (advance) begin
                if (code_idx_q == CHIP_LAST) begin
                    g1_d       = '1;
                    g2_d       = '1;
                    code_idx_d = '0;
                end else begin
                    g1_d       = g1_step;
                    g2_d       = g2_step;
                    code_idx_d = code_idx_q + 10'd1;
                end
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and pipeline registers; enable low freezes everything including the dump pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            freq_q       <= '0;
            ca_sel_q     <= '0;
            slew_q       <= '0;
            g1_q         <= '1;
            g2_q         <= '1;
            code_idx_q   <= '0;
            phase_q      <= '0;
            spc_cnt_q    <= '0;
            chip_cnt_q   <= '0;
            w_valid_q    <= 1'b0;
            w_last_q     <= 1'b0;
            wi_q         <= '0;
            wq_q         <= '0;
            acc_i_q      <= '0;
            acc_q_q      <= '0;
            corr_i_q     <= '0;
            corr_q_q     <= '0;
            corr_valid_q <= 1'b0;
            epoch_q      <= '0;
        end else if (enable) begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            freq_q       <= freq_d;
            ca_sel_q     <= ca_sel_d;
            slew_q       <= slew_d;
            g1_q         <= g1_d;
            g2_q         <= g2_d;
            code_idx_q   <= code_idx_d;
            phase_q      <= phase_d;
            spc_cnt_q    <= spc_cnt_d;
            chip_cnt_q   <= chip_cnt_d;
            w_valid_q    <= w_valid_d;
            w_last_q     <= w_last_d;
            wi_q         <= wi_d;
            wq_q         <= wq_d;
            acc_i_q      <= acc_i_d;
            acc_q_q      <= acc_q_d;
            corr_i_q     <= corr_i_d;
            corr_q_q     <= corr_q_d;
            corr_valid_q <= corr_valid_d;
            epoch_q      <= epoch_d;
        end
    end

    assign busy       = busy_q;
    assign corr_i     = corr_i_q;
    assign corr_q     = corr_q_q;
    assign corr_valid = corr_valid_q;
    assign epoch_cnt  = epoch_q;

endmodule

// File: tb/tb_gps_ca_correlator.sv
// tb/tb_gps_ca_correlator.sv - scoreboard bench for gps_ca_correlator
`timescale 1ns/1ps
module tb_gps_ca_correlator;

    localparam int SPC   = 4;
    localparam int ACC_W = 24;
    localparam int EPOCH = 1023 * SPC;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       real_in = 3'd0;
    logic [2:0]       imag_in = 3'd0;
    logic [31:0]      freq = 32'd0;
    logic [5:0]       ca_sel = 6'd0;
    logic [9:0]       code_phase = 10'd0;
    logic             busy;
    logic             code_chip;
    logic [ACC_W-1:0] corr_i;
    logic [ACC_W-1:0] corr_q;
    logic             corr_valid;
    logic [15:0]      epoch_cnt;

    gps_ca_correlator #(.SPC(SPC), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .real_in    (real_in),
        .imag_in    (imag_in),
        .freq       (freq),
        .ca_sel     (ca_sel),
        .code_phase (code_phase),
        .start      (start),
        .busy       (busy),
        .code_chip  (code_chip),
        .corr_i     (corr_i),
        .corr_q     (corr_q),
        .corr_valid (corr_valid),
        .epoch_cnt  (epoch_cnt)
    );

    always #5 clk = ~clk;

    longint rcyc = 0;
    always @(posedge clk) rcyc = rcyc + 1;

    typedef struct {
        longint ci;
        longint cq;
        longint ep;
        longint rc;
    } exp_t;

    exp_t       sb[$];
    int         vec = 0;
    int         errs = 0;
    bit         code1[1023];
    logic [9:0] code_seen;
    longint     r1;

    task automatic chk(input string name, input longint act, input longint exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference PRN 1 code from the IS-GPS-200 register definitions
    task automatic gen_prn1();
        bit [10:1] g1;
        bit [10:1] g2;
        g1 = '1;
        g2 = '1;
        for (int j = 0; j < 1023; j++) begin
            code1[j] = g1[10] ^ g2[2] ^ g2[6];
            g1 = {g1[9:1], g1[3] ^ g1[10]};
            g2 = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
        end
    endtask

    task automatic samp(input int mode, input int t, output logic [2:0] r, output logic [2:0] i);
        bit c;
        c = code1[(t / SPC) % 1023];
        r = 3'd0;
        i = 3'd0;
        case (mode)
            1:       i = c ? 3'b110 : 3'b010;
            2:       r = ((c ? 1 : 0) ^ (t % 2)) != 0 ? 3'b101 : 3'b011;
            default: r = c ? 3'b101 : 3'b011;
        endcase
    endtask

    // Called and returns at a negedge; issues start, pushes expected dumps, drives samples
    task automatic run(input logic [31:0] f, input logic [5:0] sel, input logic [9:0] cp,
                       input int mode, input int n_samp, input int n_dumps,
                       input longint eci, input longint ecq, input int stall_at, input int stall_len);
        longint     rs;
        int         slew;
        exp_t       e;
        logic [2:0] r;
        logic [2:0] i;
        start      = 1'b1;
        freq       = f;
        ca_sel     = sel;
        code_phase = cp;
        enable     = 1'b1;
        real_in    = 3'd0;
        imag_in    = 3'd0;
        rs   = rcyc + 1;
        slew = (cp == 10'd0) ? 1 : int'(cp);
        for (int m = 0; m < n_dumps; m++) begin
            e.ci = eci;
            e.cq = ecq;
            e.ep = m + 1;
            e.rc = rs + 1 + slew + longint'(EPOCH) * (m + 1)
                 + ((stall_at >= 0 && stall_at < EPOCH * (m + 1)) ? stall_len : 0);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("epoch_cnt_after_start", epoch_cnt, 0);
        repeat (slew) @(negedge clk);
        for (int t = 0; t < n_samp; t++) begin
            if (t == stall_at) begin
                enable = 1'b0;
                repeat (stall_len) @(negedge clk);
                enable = 1'b1;
            end
            if (t % SPC == 0 && t / SPC < 10) code_seen[9 - t / SPC] = code_chip;
            samp(mode, t, r, i);
            real_in = r;
            imag_in = i;
            @(negedge clk);
        end
        real_in = 3'd0;
        imag_in = 3'd0;
    endtask

    // Monitor: every enabled-edge corr_valid pops one expectation
    initial begin
        exp_t e;
        logic en_s;
        forever begin
            @(posedge clk);
            en_s = enable;
            #1;
            if (rst_n && en_s && corr_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_corr_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("corr_i", $signed(corr_i), e.ci);
                    chk("corr_q", $signed(corr_q), e.cq);
                    chk("epoch_cnt", epoch_cnt, e.ep);
                    chk("dump_cycle", rcyc, e.rc);
                end
            end
        end
    end

    initial begin
        #1000000;
        errs++;
        $display("FAIL watchdog: got time limit, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        longint ci_abs;
        gen_prn1();
        r1 = 0;
        for (int j = 0; j < 1023; j++) r1 += (code1[j] == code1[(j + 1) % 1023]) ? 1 : -1;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_code_chip", code_chip, 1);
        chk("rst_corr_i", corr_i, 0);
        chk("rst_corr_q", corr_q, 0);
        chk("rst_corr_valid", corr_valid, 0);
        chk("rst_epoch_cnt", epoch_cnt, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        code_seen = '0;
        run(32'd0, 6'd0, 10'd0, 0, 2 * EPOCH + 4, 2, 12276, -12276, -1, 0);
        chk("prn1_code", code_seen, 10'b1100100000);

        code_seen = '0;
        run(32'd0, 6'd1, 10'd0, 0, 40, 0, 0, 0, -1, 0);
        chk("prn2_code", code_seen, 10'b1110010000);

        run(32'd0, 6'd0, 10'd0, 1, EPOCH + 4, 1, 8184, 8184, -1, 0);
        run(32'h8000_0000, 6'd0, 10'd0, 2, EPOCH + 4, 1, 12276, -12276, -1, 0);
        run(32'h4000_0000, 6'd0, 10'd0, 3, EPOCH + 4, 1, 0, 0, -1, 0);

        run(32'd0, 6'd0, 10'd1, 0, EPOCH + 4, 1, 12 * r1, -12 * r1, -1, 0);
        ci_abs = $signed(corr_i);
        if (ci_abs < 0) ci_abs = -ci_abs;
        chk("offpeak_bound", (ci_abs <= 780) ? 1 : 0, 1);

        run(32'd0, 6'd0, 10'd0, 0, EPOCH + 4, 1, 12276, -12276, 1500, 100);

        run(32'd0, 6'd0, 10'd0, 0, 2000, 0, 0, 0, -1, 0);
        run(32'd0, 6'd0, 10'd0, 0, EPOCH, 0, 0, 0, -1, 0);
        run(32'd0, 6'd0, 10'd0, 0, EPOCH + 4, 1, 12276, -12276, -1, 0);

        run(32'd0, 6'd0, 10'd0, 0, 1000, 0, 0, 0, -1, 0);
        chk("held_corr_i", $signed(corr_i), 12276);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_code_chip", code_chip, 1);
        chk("async_rst_corr_i", corr_i, 0);
        chk("async_rst_corr_q", corr_q, 0);
        chk("async_rst_corr_valid", corr_valid, 0);
        chk("async_rst_epoch_cnt", epoch_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("busy_after_release", busy, 0);

        chk("pending_dumps", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
